// File: rtl/prga_pkg.sv
// prga_pkg: state encoding and timing constants for the RC4 keystream/decrypt engine.
package prga_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEN_RD,
        LEN_WR,
        RD_I,
        RD_J,
        WR_I,
        WR_J,
        RD_PAD,
        WR_PT
    } state_e;

    localparam int CYCLES_PER_BYTE = 6;
    localparam int LEN_OVERHEAD    = 2;

endpackage

// File: rtl/prga.sv
// prga: RC4 pseudo-random generation; permutes S in s_mem and decrypts a
// length-prefixed ciphertext memory into the plaintext memory.
module prga
    import prga_pkg::*;
#(
    parameter int MSG_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [7:0]        s_addr,
    input  logic [7:0]        s_rddata,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    output logic [MSG_AW-1:0] ct_addr,
    input  logic [7:0]        ct_rddata,
    output logic [MSG_AW-1:0] pt_addr,
    output logic [7:0]        pt_wrdata,
    output logic              pt_wren
);

    state_e            state_q, state_d;
    logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [MSG_AW-1:0] k_q, k_d, l_q, l_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            k_q     <= '0;
            l_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            k_q     <= k_d;
            l_q     <= l_d;
        end
    end

    // Outputs are decoded from the current state so an async reset clears them in the same cycle.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        k_d       = k_q;
        l_d       = l_q;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = MSG_AW'(1);
                    state_d = LEN_RD;
                end
            end
            LEN_RD: state_d = LEN_WR;
            LEN_WR: begin
                l_d       = MSG_AW'(ct_rddata);
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                state_d   = (ct_rddata == 8'd0) ? IDLE : RD_I;
            end
            RD_I: begin
                i_d     = i_q + 8'd1;
                s_addr  = i_q + 8'd1;
                state_d = RD_J;
            end
            RD_J: begin
                si_d    = s_rddata;
                j_d     = j_q + s_rddata;
                s_addr  = j_q + s_rddata;
                state_d = WR_I;
            end
            WR_I: begin
                sj_d     = s_rddata;
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = WR_J;
            end
            WR_J: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = RD_PAD;
            end
            RD_PAD: begin
                s_addr  = si_q + sj_q;
                ct_addr = k_q;
                state_d = WR_PT;
            end
            WR_PT: begin
                pt_addr   = k_q;
                pt_wrdata = s_rddata ^ ct_rddata;
                pt_wren   = 1'b1;
                k_d       = (k_q == l_q) ? k_q : k_q + MSG_AW'(1);
                state_d   = (k_q == l_q) ? IDLE : RD_I;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prga.sv
// tb_prga: randomized and directed checks of prga against a plain RC4 reference model.
module tb_prga;
    import prga_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic       rdy, s_wren, pt_wren;
    logic [7:0] s_addr, s_wrdata, s_rddata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
    logic [7:0] s_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ref_s [256];
    logic [7:0] exp_pt [256];
    int         n_cmp = 0, n_bad = 0;
    int         idle_wr = 0, s_wr_cnt = 0;

    always #5 clk = ~clk;

    prga #(.MSG_AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end

    always @(negedge clk) begin
        if (rst_n && rdy && (s_wren || pt_wren)) idle_wr++;
        if (s_wren) s_wr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0 identity, 1 all FF, 2 random bytes
    task automatic load_s(input int mode);
        logic [7:0] v;
        for (int x = 0; x < 256; x++) begin
            v = (mode == 0) ? 8'(x) : (mode == 1) ? 8'hFF : 8'($urandom);
            s_mem[x] <= v;
            ref_s[x] = v;
            pt_mem[x] <= 8'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic load_ct(input int len);
        ct_mem[0] = 8'(len);
        for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom);
    endtask

    // Textbook RC4 keystream, applied to ref_s which persists across runs.
    task automatic model(input int len);
        logic [7:0] i = 0, j = 0, t;
        exp_pt[0] = 8'(len);
        for (int k = 1; k <= len; k++) begin
            i = i + 8'd1;
            j = j + ref_s[i];
            t = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
            exp_pt[k] = ct_mem[k] ^ ref_s[8'(ref_s[i] + ref_s[j])];
        end
    endtask

    // mode 0 single pulse, 1 en held for the whole run, 2 en toggled mid-run
    task automatic run_check(input string tag, input int len, input int mode);
        int cnt = 0, w0, sbad = 0;
        model(len);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        if (mode != 1) en = 1'b0;
        w0 = s_wr_cnt;
        while (!rdy && cnt < 3000) begin
            cnt++;
            if (mode == 2) en = cnt[1];
            @(negedge clk);
        end
        en = 1'b0;
        check({tag, "_rdylow"}, cnt, LEN_OVERHEAD + CYCLES_PER_BYTE * len);
        check({tag, "_swrites"}, s_wr_cnt - w0, 2 * len);
        @(negedge clk);
        check({tag, "_rdy_stays"}, rdy, 1);
        for (int k = 0; k <= len; k++) check($sformatf("%s_pt%0d", tag, k), pt_mem[k], exp_pt[k]);
        for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) sbad++;
        check({tag, "_s_bad"}, sbad, 0);
    endtask

    initial begin
        int cnt;
        repeat (2) @(negedge clk);
        check("rst_rdy", rdy, 1);
        check("rst_swren", s_wren, 0);
        check("rst_ptwren", pt_wren, 0);
        check("rst_saddr", s_addr, 0);
        check("rst_ctaddr", ct_addr, 0);
        check("rst_ptaddr", pt_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        load_s(0); load_ct(1); ct_mem[1] = 8'h00;
        run_check("id1", 1, 0);
        check("id1_lit_pt1", pt_mem[1], 8'h02);
        check("id1_lit_s1", s_mem[1], 8'h01);
        check("id1_lit_s2", s_mem[2], 8'h02);

        load_s(0); load_ct(2); ct_mem[1] = 8'h00; ct_mem[2] = 8'h00;
        run_check("id2", 2, 0);
        check("id2_lit_pt2", pt_mem[2], 8'h05);
        check("id2_lit_s2", s_mem[2], 8'h03);
        check("id2_lit_s3", s_mem[3], 8'h02);

        load_s(2); load_ct(0);
        run_check("len0", 0, 0);

        load_s(1); load_ct(1); ct_mem[1] = 8'h0F;
        run_check("ff", 1, 0);
        check("ff_lit_pt1", pt_mem[1], 8'hF0);

        load_s(2); load_ct(5);
        run_check("hold", 5, 1);
        load_ct(4);
        run_check("repulse", 4, 2);

        load_s(2); load_ct(10);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        cnt = 0;
        while (!s_wren && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("rst_mid_found_wr", s_wren, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rdy", rdy, 1);
        check("rst_mid_swren", s_wren, 0);
        check("rst_mid_ptwren", pt_wren, 0);
        @(negedge clk);
        rst_n = 1'b1;
        load_s(2); load_ct(7);
        run_check("after_rst", 7, 0);

        load_s(2);
        for (int r = 0; r < 6; r++) begin
            load_ct(int'($urandom_range(1, 40)));
            run_check($sformatf("rnd%0d", r), int'(ct_mem[0]), 0);
        end
        load_ct(255);
        run_check("max", 255, 0);

        check("idle_writes", idle_wr, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prga.md
Name: prga

Overview:
- RC4 pseudo-random generation and decryption engine. It is the consumer end of the key-scheduling stage.
- Once init and ksa have left a scheduled S in s_mem, prga reads and permutes S, generates the keystream, and decrypts a length-prefixed ciphertext memory into a plaintext memory.
- It is started by the top-level control FSM through the same en/rdy handshake used by init and ksa. The top muxes s_mem to prga while prga is busy.

Parameters:
- MSG_AW, 8, address width of the ciphertext and plaintext memories. Byte 0 holds the length, so the maximum message is 255 bytes.

Ports:
- clk  input  1  system clock (CLOCK_50 at top)
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  start request; sampled only while rdy=1
- rdy  output  1  high when idle and able to accept en
- s_addr  output  8  s_mem address
- s_rddata  input  8  s_mem q
- s_wrdata  output  8  s_mem write data
- s_wren  output  1  s_mem write enable
- ct_addr  output  MSG_AW  ciphertext memory address (read-only)
- ct_rddata  input  8  ciphertext memory q
- pt_addr  output  MSG_AW  plaintext memory address
- pt_wrdata  output  8  plaintext write data
- pt_wren  output  1  plaintext write enable

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, rdy=1, i=j=k=L=0, all addr/wrdata=0, s_wren=pt_wren=0.
- Memory model:
  - All memories are synchronous single-port RAMs.
  - An address presented in cycle t gives rddata valid in cycle t+1.
  - A write presented in cycle t is visible to a read addressed in cycle t+1.
- Handshake:
  - The en=1 && rdy=1 edge starts a run. rdy drops the next cycle.
  - en while rdy=0 is ignored.
  - rdy stays 0 for exactly 2+6L cycles, then returns to 1 in IDLE.
- States and transitions:
  - IDLE: rdy=1. On en, clear i=j=0, k=1, go to LEN_RD.
  - LEN_RD: ct_addr=0. Go to LEN_WR.
  - LEN_WR: L=ct_rddata; write pt[0]=ct_rddata. If ct_rddata==0 go to IDLE, else go to RD_I.
  - RD_I: i<=i+1; s_addr=i+1. Go to RD_J.
  - RD_J: si<=s_rddata; j<=j+s_rddata; s_addr=j+s_rddata. Go to WR_I.
  - WR_I: sj<=s_rddata; s_addr=i, s_wrdata=s_rddata, s_wren=1. Go to WR_J.
  - WR_J: s_addr=j, s_wrdata=si, s_wren=1. Go to RD_PAD.
  - RD_PAD: s_addr=si+sj; ct_addr=k. Go to WR_PT.
  - WR_PT: pt_addr=k, pt_wrdata=s_rddata^ct_rddata, pt_wren=1. If k==L go to IDLE; else k<=k+1 and go to RD_I.
- Arithmetic: all S-index sums are 8-bit modulo 256 (natural truncation). k and L are MSG_AW bits wide.
- Boundary conditions:
  - i==j: the swap writes the same value twice; this is legal.
  - si+sj equal to i or j: RD_PAD reads the post-swap value.
  - L=0: no S access and no keystream.
  - L=255: i ends at 255 and never wraps within one run.
- Write enables are high for exactly one cycle per write and are never high in IDLE.
- Reset mid-run: abort immediately to reset values. S and pt contents are left as partially written; no rollback.
- A new run after completion restarts with i=j=0 on the current S contents. S is not reinitialised.

Decomposition:
- prga_pkg holds:
  - the state enum (IDLE, LEN_RD, LEN_WR, RD_I, RD_J, WR_I, WR_J, RD_PAD, WR_PT);
  - constant CYCLES_PER_BYTE=6;
  - constant LEN_OVERHEAD=2.
- No sub-module: a single FSM with a datapath. The top-level extends its existing control FSM with STARTP/PRGA states and an s_mem mux, following the init/ksa pattern.

Test Plan:
- S identity (S[x]=x), ct={01,00}, pulse en -> pt={01,02}; rdy low exactly 8 cycles; afterwards S[1]=1, S[2]=2.
- S identity, ct={02,00,00} -> pt={02,02,05}; afterwards S[2]=03, S[3]=02.
- ct={00} -> pt[0]=00; rdy low exactly 2 cycles; s_wren never asserted.
- All S=FF, ct={01,0F} -> j wraps to FF; pad=FF; pt[1]=F0.
- en held high during a run, and re-pulsed mid-run -> no restart; rdy timing unchanged; second run starts only after rdy=1.
- rst_n asserted during WR_I -> same cycle: rdy=1, s_wren=pt_wren=0. A subsequent en completes a correct new run.
